// File: rtl/noc_v2_sched.sv
// Sequences one masked row-wise tree reduction through the noc_v2 adder network per command:
// captures a PE snapshot, steps log2(NUM_PEs_PER_ROW) add stages, returns the reduced vector.
module noc_v2_sched #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_PEs_PER_ROW = 4,
    parameter int unsigned NUM_ROWS        = 4,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]            cmd_mask,
    input  logic                                        pe_data_valid,
    input  logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] pe_data,
    output logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] noc_pe_row_out_flat,
    output logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]            noc_visible,
    output logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]            noc_adder_en,
    input  logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] noc_result,
    input  logic                                        noc_ready,
    output logic                                        res_valid,
    input  logic                                        res_ready,
    output logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] res_data,
    output logic                                        res_err
);

    localparam int unsigned N  = NUM_ROWS * NUM_PEs_PER_ROW;
    localparam int unsigned NW = N * DATA_WIDTH;
    localparam int unsigned S  = $clog2(NUM_PEs_PER_ROW);
    localparam int unsigned SW = (S > 1) ? $clog2(S) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [SW-1:0] S_LAST = (S == 0) ? '0 : SW'(S - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STAGE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    mask_q,  mask_d;
    logic [NW-1:0]   data_q,  data_d;
    logic [SW-1:0]   s_q,     s_d;
    logic [TW-1:0]   t_q,     t_d;
    logic            err_q,   err_d;

    logic [NW-1:0]   masked_c;
    logic [N-1:0]    adder_en_c;

    // Snapshot with non-participating lanes zeroed so they contribute nothing to the sums.
    always_comb begin
        masked_c = pe_data;
        for (int unsigned i = 0; i < N; i++) begin
            if (!mask_q[i]) begin
                masked_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    // Receiver lanes at stage s are the multiples of 2^(s+1) within each row.
    always_comb begin
        adder_en_c = '0;
        if (state_q == ST_STAGE) begin
            for (int unsigned i = 0; i < N; i++) begin
                adder_en_c[i] = mask_q[i] &&
                    (((i % NUM_PEs_PER_ROW) % (32'd1 << (32'(s_q) + 32'd1))) == 32'd0);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        s_d     = s_q;
        t_d     = t_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mask_d  = cmd_mask;
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (pe_data_valid) begin
                    data_d  = masked_c;
                    s_d     = '0;
                    state_d = (S == 0) ? ST_DONE : ST_STAGE;
                end
            end
            ST_STAGE: begin
                t_d     = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready takes priority over an expiring timeout on the same cycle.
                if (noc_ready) begin
                    data_d = noc_result;
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = SW'(s_q + 1'b1);
                        state_d = ST_STAGE;
                    end
                end else if (t_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    t_d = TW'(t_q + 1'b1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            data_q  <= '0;
            s_q     <= '0;
            t_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            s_q     <= s_d;
            t_q     <= t_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready           = (state_q == ST_IDLE);
    assign res_valid           = (state_q == ST_DONE);
    assign noc_visible         = (state_q inside {ST_LOAD, ST_STAGE, ST_WAIT}) ? mask_q : '0;
    assign noc_adder_en        = adder_en_c;
    assign noc_pe_row_out_flat = data_q;
    assign res_data            = data_q;
    assign res_err             = err_q;

endmodule

// File: tb/tb_noc_v2_sched.sv
// Bench for noc_v2_sched: per-transaction expected traces built from the reduction rules,
// compared cycle by cycle, plus literal pins, reset abort and a single-PE-per-row instance.
module tb_noc_v2_sched;

    localparam int unsigned DW   = 8;
    localparam int unsigned PPR  = 4;
    localparam int unsigned NR   = 4;
    localparam int unsigned N    = NR * PPR;
    localparam int unsigned NW   = N * DW;
    localparam int unsigned TO   = 8;
    localparam int unsigned S    = 2;
    localparam int          MAXC = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, pe_data_valid, noc_ready;
    logic          res_valid, res_ready, res_err;
    logic [N-1:0]  cmd_mask, noc_visible, noc_adder_en;
    logic [NW-1:0] pe_data, noc_pe_row_out_flat, noc_result, res_data;

    logic          d1_cmd_valid, d1_cmd_ready, d1_pe_data_valid, d1_noc_ready;
    logic          d1_res_valid, d1_res_ready, d1_res_err;
    logic [3:0]    d1_cmd_mask, d1_noc_visible, d1_noc_adder_en;
    logic [31:0]   d1_pe_data, d1_noc_flat, d1_noc_result, d1_res_data;

    int checks = 0;
    int errors = 0;

    // Model state carried between transactions.
    logic [NW-1:0] m_data;
    logic          m_err;

    // Expected trace and stimulus, indexed by cycle within a transaction.
    logic          t_crdy[MAXC], t_rv[MAXC], t_err[MAXC];
    logic [N-1:0]  t_vis[MAXC], t_en[MAXC], t_cm[MAXC];
    logic [NW-1:0] t_flat[MAXC], t_pd[MAXC], t_nres[MAXC];
    logic          t_cv[MAXC], t_pv[MAXC], t_nr[MAXC], t_rr[MAXC];
    logic          o_rv[MAXC], o_err[MAXC];
    logic [N-1:0]  o_en[MAXC], o_vis[MAXC];
    logic [NW-1:0] o_flat[MAXC];

    always #5 clk = ~clk;

    noc_v2_sched #(.DATA_WIDTH(DW), .NUM_PEs_PER_ROW(PPR), .NUM_ROWS(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mask(cmd_mask),
        .pe_data_valid(pe_data_valid), .pe_data(pe_data),
        .noc_pe_row_out_flat(noc_pe_row_out_flat), .noc_visible(noc_visible),
        .noc_adder_en(noc_adder_en), .noc_result(noc_result), .noc_ready(noc_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    noc_v2_sched #(.DATA_WIDTH(8), .NUM_PEs_PER_ROW(1), .NUM_ROWS(4), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_mask(d1_cmd_mask),
        .pe_data_valid(d1_pe_data_valid), .pe_data(d1_pe_data),
        .noc_pe_row_out_flat(d1_noc_flat), .noc_visible(d1_noc_visible),
        .noc_adder_en(d1_noc_adder_en), .noc_result(d1_noc_result), .noc_ready(d1_noc_ready),
        .res_valid(d1_res_valid), .res_ready(d1_res_ready), .res_data(d1_res_data),
        .res_err(d1_res_err)
    );

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [NW-1:0] apply_mask(input logic [NW-1:0] v, input logic [N-1:0] m);
        logic [NW-1:0] r = v;
        for (int i = 0; i < N; i++) if (!m[i]) r[i*DW +: DW] = '0;
        return r;
    endfunction

    // Walk the receivers of each row: lanes 0, 2^(s+1), 2*2^(s+1), ...
    function automatic logic [N-1:0] en_pattern(input int s, input logic [N-1:0] m);
        logic [N-1:0] r = '0;
        int step = 2 << s;
        for (int row = 0; row < NR; row++)
            for (int p = 0; p < PPR; p += step) r[row*PPR + p] = m[row*PPR + p];
        return r;
    endfunction

    // Reference noc_v2: each enabled lane p absorbs lane p+2^s, wrapping in DW bits.
    function automatic logic [NW-1:0] noc_add(input logic [NW-1:0] v, input logic [N-1:0] en, input int s);
        logic [NW-1:0] r = v;
        for (int i = 0; i < N; i++)
            if (en[i]) r[i*DW +: DW] = v[i*DW +: DW] + v[(i + (1 << s))*DW +: DW];
        return r;
    endfunction

    task automatic exp_cyc(input int c, input logic crdy, input logic [N-1:0] vis,
                           input logic [N-1:0] en, input logic [NW-1:0] flat,
                           input logic rv, input logic err);
        t_crdy[c] = crdy; t_vis[c] = vis; t_en[c] = en; t_flat[c] = flat;
        t_rv[c] = rv; t_err[c] = err;
        t_cv[c] = 1'b0; t_cm[c] = N'($urandom()); t_pv[c] = 1'b0; t_pd[c] = rand_vec();
        t_nr[c] = 1'b0; t_nres[c] = rand_vec(); t_rr[c] = 1'b0;
    endtask

    // rd >= TO means noc_ready never comes for that stage.
    task automatic run_txn(input logic [N-1:0] mask, input logic [NW-1:0] snap, input int ld,
                           input int rd0, input int rd1, input int hold, input logic hold_cv,
                           input int abort_at);
        int c = 0;
        int rd;
        logic got;
        logic [NW-1:0] d = m_data;
        logic e = m_err;
        exp_cyc(c, 1'b1, '0, '0, d, 1'b0, e);
        t_cv[c] = 1'b1; t_cm[c] = mask; c++;
        e = 1'b0;
        for (int k = 0; k <= ld; k++) begin
            exp_cyc(c, 1'b0, mask, '0, d, 1'b0, 1'b0);
            if (k == ld) begin t_pv[c] = 1'b1; t_pd[c] = snap; end
            c++;
        end
        d = apply_mask(snap, mask);
        for (int s = 0; s < int'(S); s++) begin
            if (e) break;
            exp_cyc(c, 1'b0, mask, en_pattern(s, mask), d, 1'b0, 1'b0);
            t_nr[c] = 1'($urandom());
            c++;
            rd = (s == 0) ? rd0 : rd1;
            got = 1'b0;
            for (int w = 0; w < int'(TO); w++) begin
                exp_cyc(c, 1'b0, mask, '0, d, 1'b0, 1'b0);
                if (w == rd) begin
                    t_nr[c] = 1'b1;
                    if (mask != '0) t_nres[c] = noc_add(d, en_pattern(s, mask), s);
                    got = 1'b1;
                    c++;
                    d = t_nres[c-1];
                    break;
                end
                c++;
            end
            if (!got) e = 1'b1;
        end
        for (int h = 0; h <= hold; h++) begin
            exp_cyc(c, 1'b0, '0, '0, d, 1'b1, e);
            t_cv[c] = hold_cv; t_rr[c] = (h == hold);
            c++;
        end
        for (int k = 0; k < c; k++) begin
            if (k == abort_at) break;
            @(negedge clk);
            chk($sformatf("cmd_ready@%0d", k), NW'(cmd_ready), NW'(t_crdy[k]));
            chk($sformatf("visible@%0d", k), NW'(noc_visible), NW'(t_vis[k]));
            chk($sformatf("adder_en@%0d", k), NW'(noc_adder_en), NW'(t_en[k]));
            chk($sformatf("row_out@%0d", k), noc_pe_row_out_flat, t_flat[k]);
            chk($sformatf("res_data@%0d", k), res_data, t_flat[k]);
            chk($sformatf("res_valid@%0d", k), NW'(res_valid), NW'(t_rv[k]));
            chk($sformatf("res_err@%0d", k), NW'(res_err), NW'(t_err[k]));
            o_rv[k] = res_valid; o_err[k] = res_err; o_en[k] = noc_adder_en;
            o_vis[k] = noc_visible; o_flat[k] = noc_pe_row_out_flat;
            cmd_valid = t_cv[k]; cmd_mask = t_cm[k]; pe_data_valid = t_pv[k]; pe_data = t_pd[k];
            noc_ready = t_nr[k]; noc_result = t_nres[k]; res_ready = t_rr[k];
        end
        if (abort_at < 0) begin
            m_data = d;
            m_err  = e;
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_mask = '0; pe_data_valid = 1'b0; pe_data = '0;
        noc_ready = 1'b0; noc_result = '0; res_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, NW'(cmd_ready), NW'(1'b1));
        chk({tag, "_res_valid"}, NW'(res_valid), '0);
        chk({tag, "_res_err"}, NW'(res_err), '0);
        chk({tag, "_adder_en"}, NW'(noc_adder_en), '0);
        chk({tag, "_visible"}, NW'(noc_visible), '0);
        chk({tag, "_row_out"}, noc_pe_row_out_flat, '0);
        chk({tag, "_res_data"}, res_data, '0);
    endtask

    initial begin
        logic [NW-1:0] snap;
        logic [NW-1:0] lit;
        logic [N-1:0]  rm;
        int            rsel;

        idle_inputs();
        d1_cmd_valid = 1'b0; d1_cmd_mask = '0; d1_pe_data_valid = 1'b0; d1_pe_data = '0;
        d1_noc_ready = 1'b1; d1_noc_result = 32'h12345678; d1_res_ready = 1'b0;
        m_data = '0; m_err = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1 chk_reset_outputs("reset");
        chk("reset_d1_cmd_ready", NW'(d1_cmd_ready), NW'(1'b1));
        chk("reset_d1_res_valid", NW'(d1_res_valid), '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_reset_outputs("post_reset");

        // Full mask, best-case latency: row r lanes = {1,2,3,4}+r.
        for (int r = 0; r < int'(NR); r++)
            for (int p = 0; p < int'(PPR); p++) snap[(r*PPR + p)*DW +: DW] = DW'(p + 1 + r);
        run_txn('1, snap, 0, 0, 0, 0, 1'b0, -1);
        chk("lit_full_en_stage0", NW'(o_en[2]), NW'(16'h5555));
        chk("lit_full_en_stage1", NW'(o_en[4]), NW'(16'h1111));
        chk("lit_full_rv_cycle5", NW'(o_rv[5]), '0);
        chk("lit_full_rv_cycle6", NW'(o_rv[6]), NW'(1'b1));
        for (int r = 0; r < int'(NR); r++)
            chk($sformatf("lit_full_row%0d_lane0", r), NW'(m_data[(r*PPR)*DW +: DW]), NW'(10 + 4*r));

        // Partial mask over an all-0xFF snapshot, with two idle LOAD cycles.
        run_txn(16'h00F3, {16{8'hFF}}, 2, 1, 0, 0, 1'b0, -1);
        lit = 128'h00000000_00000000_FFFFFFFF_0000FFFF;
        chk("lit_part_en_stage0", NW'(o_en[4]), NW'(16'h0051));
        chk("lit_part_row_out", o_flat[4], lit);
        chk("lit_part_visible_wait", NW'(o_vis[5]), NW'(16'h00F3));

        // Timeout in stage 0: WAIT entered at cycle 3, DONE 8 cycles later.
        run_txn(16'h0F0F, {16{8'hAB}}, 0, TO, 0, 0, 1'b0, -1);
        lit = 128'h00000000_ABABABAB_00000000_ABABABAB;
        chk("lit_to_rv_cycle10", NW'(o_rv[10]), '0);
        chk("lit_to_rv_cycle11", NW'(o_rv[11]), NW'(1'b1));
        chk("lit_to_err", NW'(o_err[11]), NW'(1'b1));
        chk("lit_to_data", o_flat[11], lit);

        // Ready on the last permitted WAIT cycle of each stage is accepted.
        run_txn('1, rand_vec(), 0, TO - 1, TO - 1, 1, 1'b0, -1);
        chk("lit_edge_rv_cycle19", NW'(o_rv[19]), '0);
        chk("lit_edge_rv_cycle20", NW'(o_rv[20]), NW'(1'b1));
        chk("lit_edge_err", NW'(o_err[20]), '0);

        // Backpressure with cmd_valid held, then a back-to-back command.
        run_txn(16'hA5C3, rand_vec(), 1, 0, 2, 10, 1'b1, -1);
        run_txn(N'($urandom()), rand_vec(), 0, 0, 0, 0, 1'b0, -1);

        // Zero mask: stages still run, noc_result captured verbatim.
        run_txn('0, rand_vec(), 0, 0, 1, 0, 1'b0, -1);

        // Reset during stage-1 WAIT.
        run_txn('1, rand_vec(), 0, 0, 5, 0, 1'b0, 6);
        @(negedge clk);
        #2 rst = 1'b0;
        idle_inputs();
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        m_data = '0; m_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_cmd_ready@%0d", k), NW'(cmd_ready), NW'(1'b1));
            chk($sformatf("abort_res_valid@%0d", k), NW'(res_valid), '0);
        end

        // Randomized transactions.
        for (int n = 0; n < 25; n++) begin
            rm = N'($urandom());
            if (n % 7 == 3) rm = '0;
            rsel = int'($urandom_range(0, 9));
            run_txn(rm, rand_vec(), int'($urandom_range(0, 3)),
                    (rsel < 8) ? int'($urandom_range(0, TO - 1)) : int'(TO),
                    int'($urandom_range(0, TO)), int'($urandom_range(0, 3)),
                    1'($urandom()), -1);
        end

        // One PE per row: no stages, LOAD goes straight to DONE.
        @(negedge clk);
        d1_cmd_valid = 1'b1; d1_cmd_mask = 4'b1011;
        chk("d1_idle_cmd_ready", NW'(d1_cmd_ready), NW'(1'b1));
        @(negedge clk);
        d1_cmd_valid = 1'b0; d1_cmd_mask = 4'b0000;
        chk("d1_load_cmd_ready", NW'(d1_cmd_ready), '0);
        chk("d1_load_visible", NW'(d1_noc_visible), NW'(4'b1011));
        chk("d1_load_adder_en", NW'(d1_noc_adder_en), '0);
        d1_pe_data_valid = 1'b1; d1_pe_data = 32'hAABBCCDD;
        @(negedge clk);
        d1_pe_data_valid = 1'b0; d1_pe_data = '0;
        chk("d1_done_res_valid", NW'(d1_res_valid), NW'(1'b1));
        chk("d1_done_res_data", NW'(d1_res_data), NW'(32'hAA00CCDD));
        chk("d1_done_res_err", NW'(d1_res_err), '0);
        chk("d1_done_adder_en", NW'(d1_noc_adder_en), '0);
        chk("d1_done_visible", NW'(d1_noc_visible), '0);
        d1_res_ready = 1'b1;
        @(negedge clk);
        d1_res_ready = 1'b0;
        chk("d1_after_cmd_ready", NW'(d1_cmd_ready), NW'(1'b1));
        chk("d1_after_res_valid", NW'(d1_res_valid), '0);
        chk("d1_after_row_out", NW'(d1_noc_flat), NW'(32'hAA00CCDD));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_v2_sched.md
# noc_v2_sched

Controller that sequences one masked row-wise tree reduction through the `noc_v2` adder network per command. It accepts a command carrying a PE participation mask, latches one snapshot of PE array outputs, and drives `noc_v2`'s `pe_row_out_flat`, `visible` and `adder_en` through log2(NUM_PEs_PER_ROW) add stages, each waiting on `noc_v2`'s `ready`. It then returns the reduced vector over a valid/ready handshake. It sits between the tile control FSM / PE array and `noc_v2`.

## Interface
- `DATA_WIDTH`, 8, lane width in bits
- `NUM_PEs_PER_ROW`, 4, PEs per row; power of two, ≥1
- `NUM_ROWS`, 4, rows
- `TIMEOUT`, 64, max WAIT cycles per stage, ≥2
- Derived: N = NUM_ROWS*NUM_PEs_PER_ROW; S = clog2(NUM_PEs_PER_ROW); lane (r,p) is index i = r*NUM_PEs_PER_ROW+p, bits [i*DATA_WIDTH +: DATA_WIDTH]

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: high only in IDLE
- `cmd_mask` in N: participating lanes
- `pe_data_valid` in 1: PE snapshot valid this cycle
- `pe_data` in N*DATA_WIDTH: PE array outputs
- `noc_pe_row_out_flat` out N*DATA_WIDTH: operand vector to `noc_v2`
- `noc_visible` out N: lane visibility to `noc_v2`
- `noc_adder_en` out N: per-lane adder enables
- `noc_result` in N*DATA_WIDTH: `noc_v2` result
- `noc_ready` in 1: `noc_v2` stage complete
- `res_valid` out 1: reduced vector available
- `res_ready` in 1: consumer accepts
- `res_data` out N*DATA_WIDTH: reduced vector
- `res_err` out 1: a stage timed out; qualified by `res_valid`

## Operation
- States: IDLE, LOAD, STAGE, WAIT, DONE. Registers: mask_q (N), data_q (N*DW), stage counter s (≥1 bit), timeout counter t.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch `cmd_mask` into mask_q, clear `res_err`, go to LOAD.
- LOAD: wait for `pe_data_valid`. On that cycle:
  - latch `pe_data` into data_q with lanes where mask_q=0 forced to 0;
  - set s=0;
  - go to STAGE, or go to DONE if S=0.
- STAGE (one cycle):
  - `noc_adder_en[i]` = mask_q[i] && (p mod 2^(s+1) == 0);
  - clear t; go to WAIT;
  - `noc_ready` is ignored in this state.
- WAIT: `noc_adder_en`=0; t increments each cycle.
  - `noc_ready`=1: data_q ← `noc_result`. If s==S-1, go to DONE; otherwise s++ and go to STAGE.
  - No ready and t==TIMEOUT-1: set `res_err`=1, go to DONE; data_q keeps its last value.
- DONE: `res_valid`=1 and `res_data`=data_q, both held stable until `res_ready`; then go to IDLE.
- `noc_pe_row_out_flat` = data_q in every state.
- `noc_visible` = mask_q in LOAD/STAGE/WAIT, 0 in IDLE/DONE.
- No arithmetic is done in this block. Sums wrap modulo 2^DATA_WIDTH inside `noc_v2`; `noc_result` is captured verbatim.
- A zero `cmd_mask` is legal: all enables stay 0, stages still run, and the result is the captured `noc_result`.

## Timing
- Reset (`rst`=0, async): state=IDLE, all registers 0.
  - Outputs during and after reset: `cmd_ready`=1, `res_valid`=0, `res_err`=0, `noc_adder_en`=0, `noc_visible`=0, `noc_pe_row_out_flat`=0, `res_data`=0.
- Reset asserted mid-operation aborts immediately to IDLE. There is no pending output and no `res_valid` afterwards.
- Best-case latency, with `pe_data_valid` on the first LOAD cycle and `noc_ready` on the first WAIT cycle of each stage:
  - command accepted at edge 0; `res_valid` high at cycle 2+2S (6 for defaults).
- `cmd_ready`, `res_valid`, `noc_visible` and `noc_adder_en` are decoded from registered state. All other outputs are registered. There are no combinational input-to-output paths.
- `cmd_valid` held high in DONE is not accepted until the cycle after the `res_ready` handshake (IDLE).
- `noc_ready` and timeout expiry on the same WAIT cycle: ready wins, no error.
- Timeout boundary: ready on WAIT cycle index TIMEOUT-1 (t=TIMEOUT-1) is accepted. Ready never arriving gives `res_valid` TIMEOUT cycles after entering WAIT.

## Test plan
- Full mask, defaults:
  - Stimulus: row r lanes = {1,2,3,4}+r; `noc_v2` model adds lane p+2^s into lane p on enabled lanes; `noc_ready` one cycle after STAGE.
  - Expect: `res_valid` at cycle 6; lane (r,0)=10+4r; adder_en patterns 0x5555 (stage 0) then 0x1111 (stage 1).
- Partial mask:
  - Stimulus: `cmd_mask`=0x00F3, all `pe_data`=0xFF.
  - Expect: masked lanes appear 0 on `noc_pe_row_out_flat`; `noc_visible`=0x00F3 through WAIT; stage 0 adder_en=0x0051.
- Timeout:
  - Stimulus: TIMEOUT=8; `noc_ready` never asserted.
  - Expect: `res_err`=1 and `res_valid` 8 cycles after WAIT entry; data = masked snapshot.
- Backpressure:
  - Stimulus: hold `res_ready`=0 for 10 cycles with `cmd_valid` high.
  - Expect: `res_data` stable; `cmd_ready`=0 throughout; next command accepted 1 cycle after the handshake.
- Reset mid-WAIT:
  - Stimulus: drop `rst` during stage 1.
  - Expect: outputs zero asynchronously; `cmd_ready`=1 after release; no spurious `res_valid`.
- Degenerate case:
  - Stimulus: NUM_PEs_PER_ROW=1.
  - Expect: LOAD→DONE with masked snapshot; `noc_adder_en` never asserted.
